muldiv_unit: RTL and testbench

Iterative multi-cycle multiply/divide unit that services the M-extension side of the execute stage. It is the responder end of the execute stage's mul-request / done handshake: the execute stage raises `start` and holds it while the hazard unit stalls the pipeline. This unit computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over 32 iterations and pulses `done` for exactly one cycle with the result. Special divide cases complete early.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_unit.sv | 130 +++++++++++++
 tb/tb_muldiv_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_pkg : shared types for the iterative M-extension multiply/divide    |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
package muldiv_pkg;

  localparam int MULDIV_DW = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muldiv_unit : 32-iteration shift-add multiplier / restoring divider        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = MULDIV_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  done,
  output logic                  busy
);

  localparam int                  c_cnt_w    = $clog2(DATA_WIDTH);
  localparam logic [c_cnt_w-1:0]  c_last_cnt = c_cnt_w'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] c_min_int = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  muldiv_state_t               r_state, w_next;
  muldiv_op_t                  r_op, w_op;
  logic [c_cnt_w-1:0]          r_cnt;
  logic [2*DATA_WIDTH-1:0]     r_acc, w_acc_nxt, w_prod;
  logic [DATA_WIDTH-1:0]       r_opb, r_result;
  logic                        r_neg_q, r_neg_r;

  logic                        w_accept, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [DATA_WIDTH-1:0]       w_a_mag, w_b_mag, w_special_res, w_fix_res, w_quot, w_rem;
  logic                        w_div0, w_ovf, w_special, w_div_mode;
  logic [DATA_WIDTH:0]         w_lhs, w_rhs, w_sum;

  // Operand conditioning at accept: magnitudes plus the sign flags FIX needs.
  assign w_op      = muldiv_op_t'(op);
  assign w_accept  = (r_state == ST_IDLE) && start && !flush;
  assign w_a_sgn   = (w_op != OP_MULHU) && (w_op != OP_DIVU) && (w_op != OP_REMU);
  assign w_b_sgn   = w_a_sgn && (w_op != OP_MULHSU);
  assign w_a_neg   = w_a_sgn && a[DATA_WIDTH-1];
  assign w_b_neg   = w_b_sgn && b[DATA_WIDTH-1];
  assign w_a_mag   = w_a_neg ? -a : a;
  assign w_b_mag   = w_b_neg ? -b : b;
  assign w_div0    = op[2] && (b == '0);
  assign w_ovf     = ((w_op == OP_DIV) || (w_op == OP_REM)) && (a == c_min_int) && (b == '1);
  assign w_special = w_div0 || w_ovf;
  assign w_special_res = w_div0 ? (op[1] ? a : '1) : (op[1] ? '0 : c_min_int);

  // One shared adder: add multiplicand to upper half, or trial-subtract divisor.
  assign w_div_mode = (r_op == OP_DIV) || (r_op == OP_DIVU) || (r_op == OP_REM) || (r_op == OP_REMU);
  assign w_lhs = w_div_mode ? r_acc[2*DATA_WIDTH-1:DATA_WIDTH-1] : {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]};
  assign w_rhs = w_div_mode ? ~{1'b0, r_opb} : (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_sum = w_lhs + w_rhs + (DATA_WIDTH+1)'(w_div_mode);

  always_comb begin
    w_acc_nxt = {w_sum, r_acc[DATA_WIDTH-1:1]};
    if (w_div_mode) begin
      if (w_sum[DATA_WIDTH])
        w_acc_nxt = {r_acc[2*DATA_WIDTH-2:0], 1'b0};
      else
        w_acc_nxt = {w_sum[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b1};
    end
  end

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quot = r_neg_q ? -r_acc[DATA_WIDTH-1:0] : r_acc[DATA_WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*DATA_WIDTH-1:DATA_WIDTH] : r_acc[2*DATA_WIDTH-1:DATA_WIDTH];

  always_comb begin
    w_fix_res = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
    case (r_op)
      OP_MUL:                  w_fix_res = w_prod[DATA_WIDTH-1:0];
      OP_DIV, OP_DIVU:         w_fix_res = w_quot;
      OP_REM, OP_REMU:         w_fix_res = w_rem;
      default:                 w_fix_res = w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_special ? ST_DONE : ST_CALC;
      ST_CALC: if (r_cnt == c_last_cnt) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (flush) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= OP_MUL;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= w_op;
      r_cnt   <= '0;
      r_acc   <= {{DATA_WIDTH{1'b0}}, w_a_mag};
      r_opb   <= w_b_mag;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      if (w_special) r_result <= w_special_res;
    end else if (!flush && r_state == ST_CALC) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
    end else if (!flush && r_state == ST_FIX) begin
      r_result <= w_fix_res;
    end
  end

  assign result = r_result;
  assign done   = (r_state == ST_DONE);
  assign busy   = (r_state != ST_IDLE);

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_muldiv_unit : directed vectors for muldiv_unit                          |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b, result;
  logic        done, busy;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.DATA_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .a(a), .b(b), .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one op, wait for done, check latency, busy span, result and pulse width.
  task automatic run_op(input string tag, input logic [2:0] op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic [31:0] exp, input int exp_lat);
    int lat, nbusy;
    logic [31:0] res;
    @(negedge clk);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    lat = 0; nbusy = 0; res = 'x;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin lat = k; res = result; end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, res, exp);
    chk({tag, "_busy"}, 32'(nbusy), 32'(exp_lat));
    @(negedge clk);
    chk({tag, "_after"}, {30'd0, done, busy}, 32'd0);
  endtask

  // Start an op and abort it (flush or reset) at the given CALC iteration.
  task automatic abort_op(input string tag, input bit use_rst, input int iter,
                          input logic [31:0] exp_res);
    int ndone;
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= iter; k++) @(negedge clk);
    chk({tag, "_busy_pre"}, {31'd0, busy}, 32'd1);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk({tag, "_outs"}, {30'd0, done, busy}, 32'd0);
    chk({tag, "_result"}, result, exp_res);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk({tag, "_no_done"}, 32'(ndone), 32'd0);
  endtask

  initial begin
    int ndone, first, second;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {30'd0, done, busy}, 32'd0);
    rst = 1'b0;

    run_op("mul_7_m3",  3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulhu_ff",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulh_ff",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("mul_ff",    3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
    run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34);
    run_op("divu_100_7",3'd5, 32'd100,      32'd7,        32'd14,        34);
    run_op("div_5_0",   3'd4, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    run_op("remu_5_0",  3'd7, 32'd5,        32'd0,        32'd5,         1);
    run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("remu_100_7",3'd7, 32'd100,      32'd7,        32'd2,         34);

    abort_op("flush_it10", 1'b0, 11, 32'd2);
    run_op("divu_after_flush", 3'd5, 32'd9, 32'd3, 32'd3, 34);
    abort_op("rst_it20", 1'b1, 21, 32'd0);
    run_op("divu_after_rst", 3'd5, 32'd9, 32'd3, 32'd3, 34);

    // start held high across DONE: exactly one pulse, re-accept one cycle later
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hFFFF_FFF9; b = 32'd2;
    @(posedge clk);
    ndone = 0; first = 0; second = 0;
    for (int k = 1; k <= 75 && second == 0; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first == 0) first = k; else begin second = k; start = 1'b0; end
        chk($sformatf("held_res%0d", ndone), result, 32'hFFFF_FFFD);
      end
    end
    start = 1'b0;
    chk("held_first", 32'(first), 32'd34);
    chk("held_interval", 32'(second - first), 32'd35);
    @(negedge clk);
    chk("held_idle", {30'd0, done, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("held_no_reaccept", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_muldiv_unit
`default_nettype wire
